vga_frame_ctrl: RTL

VGA_FRAME_CTRL -- requirements
Module: vga_frame_ctrl

---
 rtl/vga_frame_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/vga_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_ctrl
// Description : Per-frame update window opened on each v_sync rising edge,
//               with a round-robin arbiter feeding the mole mask and cursor.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_ctrl #(
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        v_sync,
    input  logic        req_a,
    input  logic [8:0]  data_a,
    input  logic        req_b,
    input  logic [10:0] data_b_x,
    input  logic [9:0]  data_b_y,
    output logic        ack_a,
    output logic        ack_b,
    output logic [8:0]  mole_mask,
    output logic [10:0] cursor_x,
    output logic [9:0]  cursor_y,
    output logic        frame_tick,
    output logic [15:0] frame_cnt,
    output logic        in_window
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BLANK = 1'b1;
    localparam logic [7:0] c_LAST  = 8'(BLANK_CYCLES - 1);

    logic [0:0]  r_state;
    logic [7:0]  r_win_cnt;
    logic        r_rr;
    logic        r_vsync_d;
    logic        r_ack_a;
    logic        r_ack_b;
    logic        r_frame_tick;
    logic [15:0] r_frame_cnt;
    logic [8:0]  r_mole_mask;
    logic [10:0] r_cursor_x;
    logic [9:0]  r_cursor_y;

    logic w_rise;
    logic w_closing;
    logic w_grant_ok;
    logic w_elig_a;
    logic w_elig_b;
    logic w_grant_a;
    logic w_grant_b;

    assign w_rise     = v_sync & ~r_vsync_d;
    // No grant on the closing edge: its ack would land after the window shut.
    assign w_closing  = (r_state == c_BLANK) && (r_win_cnt == c_LAST) && !w_rise;
    assign w_grant_ok = (r_state == c_BLANK) && !w_closing;
    assign w_elig_a   = req_a & ~r_ack_a;
    assign w_elig_b   = req_b & ~r_ack_b;
    assign w_grant_a  = w_grant_ok & w_elig_a & (~w_elig_b | ~r_rr);
    assign w_grant_b  = w_grant_ok & w_elig_b & (~w_elig_a |  r_rr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_win_cnt    <= 8'd0;
            r_rr         <= 1'b0;
            r_vsync_d    <= 1'b1;
            r_ack_a      <= 1'b0;
            r_ack_b      <= 1'b0;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_mole_mask  <= 9'd0;
            r_cursor_x   <= 11'd0;
            r_cursor_y   <= 10'd0;
        end else begin
            r_vsync_d    <= v_sync;
            r_frame_tick <= w_rise;
            r_ack_a      <= w_grant_a;
            r_ack_b      <= w_grant_b;

            if (w_grant_a) begin
                r_mole_mask <= data_a;
                r_rr        <= 1'b1;
            end
            if (w_grant_b) begin
                r_cursor_x <= data_b_x;
                r_cursor_y <= data_b_y;
                r_rr       <= 1'b0;
            end

            if (w_rise) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_state     <= c_BLANK;
                r_win_cnt   <= 8'd0;
            end else if (r_state == c_BLANK) begin
                if (r_win_cnt == c_LAST) begin
                    r_state   <= c_IDLE;
                    r_win_cnt <= 8'd0;
                end else begin
                    r_win_cnt <= r_win_cnt + 8'd1;
                end
            end
        end
    end

    assign ack_a      = r_ack_a;
    assign ack_b      = r_ack_b;
    assign mole_mask  = r_mole_mask;
    assign cursor_x   = r_cursor_x;
    assign cursor_y   = r_cursor_y;
    assign frame_tick = r_frame_tick;
    assign frame_cnt  = r_frame_cnt;
    assign in_window  = (r_state == c_BLANK);

endmodule
`default_nettype wire
